seq_det_ctrl: RTL and testbench

- Programmable serial pattern-detector controller for the sequence-detection path.
- Accepts a configuration (pattern, length, overlap mode, match threshold) over a valid/ready handshake.
- Arms and disarms detection, counts matches, and flags completion when the threshold is reached.
- Sits between the control/CSR side and the raw serial input `in`, replacing fixed-pattern detectors.

---
 rtl/seq_det_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: handshake-loaded config, arm/disarm, match counting.
// Optional idle watchdog enabled by defining SEQ_DET_CTRL_TIMEOUT_EN.
module seq_det_ctrl #(
  parameter int MAXLEN  = 8,
  parameter int LENW    = 4,
  parameter int CNTW    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_thresh,
  input  logic              start,
  input  logic              stop,
  output logic              match,
  output logic [CNTW-1:0]   count,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t            state;
  logic [MAXLEN-1:0] pat_q;
  logic [LENW-1:0]   len_q;
  logic              ovl_q;
  logic [CNTW-1:0]   thr_q;
  // The oldest bit never takes part in a compare, so only MAXLEN-1 bits are kept.
  logic [MAXLEN-2:0] hist;
  logic [LENW-1:0]   fill;

  logic              cfg_fire;
  logic [LENW-1:0]   len_clamped;
  logic [MAXLEN-1:0] hist_nxt;
  logic [MAXLEN-1:0] mask;
  logic [LENW:0]     fill_p1;
  logic              hit;
  logic [CNTW-1:0]   count_inc;
  logic              thresh_hit;

  assign cfg_fire  = cfg_valid & cfg_ready;
  assign hist_nxt  = {hist, in};
  assign fill_p1   = {1'b0, fill} + (LENW+1)'(1);
  assign count_inc = (&count) ? count : count + CNTW'(1);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)                  len_clamped = LENW'(1);
    else if (int'(cfg_len) > MAXLEN)    len_clamped = LENW'(MAXLEN);
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len_q));
  end

  assign hit = (state == S_ARMED) && (fill_p1 >= {1'b0, len_q}) &&
               (((hist_nxt ^ pat_q) & mask) == '0);
  assign thresh_hit = hit && (thr_q != '0) && (count_inc == thr_q);

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WDW-1:0] wd;
  logic           timeout_q;
  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT);
  assign timeout = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pat_q     <= MAXLEN'(5'b11010);
      len_q     <= LENW'(5);
      ovl_q     <= 1'b1;
      thr_q     <= '0;
      hist      <= '0;
      fill      <= '0;
      match     <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      wd        <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      match <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      if (cfg_fire) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
        ovl_q <= cfg_overlap;
        thr_q <= cfg_thresh;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            state     <= S_ARMED;
            count     <= '0;
            hist      <= '0;
            fill      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            wd        <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (stop) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            hist <= hist_nxt[MAXLEN-2:0];
            if (hit && !ovl_q)                fill <= '0;
            else if (int'(fill) < MAXLEN)     fill <= fill + LENW'(1);
            if (hit) begin
              match <= 1'b1;
              count <= count_inc;
            end
            if (thresh_hit) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
            end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            // A hit on the expiry edge wins and restarts the watchdog.
            if (hit) begin
              wd <= '0;
            end else if (int'(wd) >= TIMEOUT - 1) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              wd <= wd + WDW'(1);
            end
`endif
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus pushes expected match events, a monitor pops them.
module tb_seq_det_ctrl;
  localparam int MAXLEN = 8;
  localparam int LENW   = 4;
  localparam int CNTW   = 8;
  localparam int TO     = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_thresh;
  logic              start;
  logic              stop;
  logic              match;
  logic [CNTW-1:0]   count;
  logic              busy;
  logic              done;
  logic              timeout;

  int checks   = 0;
  int failures = 0;
  int bit_idx  = 0;

  typedef struct {
    int            bit_no;
    logic [CNTW-1:0] cnt;
    logic          dn;
  } exp_t;
  exp_t sb[$];

  seq_det_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in(in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .start(start), .stop(stop), .match(match), .count(count),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int b, input int c, input logic d);
    exp_t e;
    e.bit_no = b;
    e.cnt    = CNTW'(c);
    e.dn     = d;
    sb.push_back(e);
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_thresh  = t;
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Bits are sent MSB first; bit_idx numbers them from 1 within this call.
  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      in      = bits[n-1-i];
      bit_idx = i + 1;
      step();
    end
    in = 1'b0;
  endtask

  task automatic sb_empty(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: samples away from the clock edge and pops one expected event per match pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && match) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_match: got match=1 count=%0d expected no match (bit %0d)", count, bit_idx);
        end else begin
          e = sb.pop_front();
          check("match_bit", bit_idx, e.bit_no);
          check("match_count", count, e.cnt);
          check("match_done", done, e.dn);
        end
      end
`ifndef SEQ_DET_CTRL_TIMEOUT_EN
      if (timeout) check("timeout_tied", timeout, 0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish expected finish before limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_thresh = '0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_match", match, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    step();

    // Default pattern 11010, overlapping.
    do_start();
    check("armed_busy", busy, 1);
    check("armed_cfg_ready", cfg_ready, 0);
    push(5, 1, 0); push(10, 2, 0);
    send(16'b1101011010, 10);
    sb_empty("t1_missing");
    check("t1_count", count, 2);
    check("t1_busy", busy, 1);
    check("t1_done", done, 0);
    do_stop();
    check("t1_stop_busy", busy, 0);
    check("t1_stop_count_held", count, 2);

    // 101 with and without overlap.
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    push(3, 1, 0); push(5, 2, 0);
    send(16'b10101, 5);
    sb_empty("t2_missing");
    check("t2_count", count, 2);
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    do_start();
    push(3, 1, 0);
    send(16'b10101, 5);
    sb_empty("t3_missing");
    check("t3_count", count, 1);
    do_stop();

    // Threshold 2: done rises with the second match, later input ignored.
    do_cfg(8'b101, 4'd3, 1'b1, 8'd2);
    do_start();
    push(3, 1, 0); push(6, 2, 1);
    send(16'b101101101, 9);
    sb_empty("t4_missing");
    check("t4_count", count, 2);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_cfg_ready", cfg_ready, 1);

    // Config offered while armed stays pending; stop holds count; handshake plus start uses new config.
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    check("t5_done_still", done, 1);
    do_start();
    check("t5_done_drop", done, 0);
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1; cfg_thresh = 8'd0;
    cfg_valid = 1'b1;
    step();
    check("t5_cfg_ready_armed", cfg_ready, 0);
    push(4, 1, 0);
    send(16'b1101, 4);
    sb_empty("t5_old_cfg");
    check("t5_count", count, 1);
    do_stop();
    check("t5_stop_busy", busy, 0);
    check("t5_stop_count", count, 1);
    do_start();
    cfg_valid = 1'b0;
    check("t5_rearmed", busy, 1);
    push(3, 1, 0);
    send(16'b011, 3);
    sb_empty("t5_new_cfg");
    check("t5_new_count", count, 1);
    do_stop();

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);

    // Length boundaries: 0 behaves as 1, above MAXLEN clamps to MAXLEN.
    do_cfg(8'h01, 4'd0, 1'b1, 8'd0);
    do_start();
    push(1, 1, 0); push(3, 2, 0);
    send(16'b101, 3);
    sb_empty("len0_missing");
    do_stop();
    do_cfg(8'hA5, 4'd15, 1'b0, 8'd0);
    do_start();
    push(8, 1, 0);
    send(16'b10100101, 8);
    sb_empty("len15_missing");
    check("len15_count", count, 1);
    do_stop();

    // Reset mid-pattern restores defaults and clears history.
    do_cfg(8'b010, 4'd3, 1'b1, 8'd0);
    do_start();
    send(16'b110, 3);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_match", match, 0);
    check("t6_rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    step();
    do_start();
    send(16'b10, 2);
    sb_empty("t6_no_match");
    check("t6_count_zero", count, 0);
    push(5, 1, 0);
    send(16'b11010, 5);
    sb_empty("t6_default_cfg");
    do_stop();

    // Watchdog: TO idle cycles in ARMED.
    do_start();
    send(16'h0000, TO);
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    check("to_pulse", timeout, 1);
    check("to_busy", busy, 0);
    check("to_cfg_ready", cfg_ready, 1);
    step();
    check("to_pulse_end", timeout, 0);
`else
    check("to_tied", timeout, 0);
    check("to_still_armed", busy, 1);
    do_stop();
`endif
    sb_empty("final_queue");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
